// File: rtl/peri_timer_if.sv
// peri_timer_if: peribus signals between the controller and the timer peripheral
interface peri_timer_if;
  logic [7:0]  addr;
  logic [15:0] write_data;
  logic        write_enable;
  logic        read_enable;
  logic [15:0] read_data;
  logic        irq;
  modport master (output addr, write_data, write_enable, read_enable, input read_data, irq);
  modport slave  (input addr, write_data, write_enable, read_enable, output read_data, irq);
endinterface

// File: rtl/peri_timer.sv
// peri_timer: 16-bit prescaled down-counter with one-shot/periodic modes and sticky expiry irq
module peri_timer #(
  parameter logic [7:0]  BASE_ADDR      = 8'h00,
  parameter logic [15:0] RESET_PRESCALE = 16'h0000
) (
  input logic         clock,
  input logic         reset,
  peri_timer_if.slave bus
);
  logic        en_q, en_d, periodic_q, periodic_d, irq_en_q, irq_en_d, expired_q, expired_d;
  logic [15:0] load_q, load_d, count_q, count_d, prescale_q, prescale_d;
  logic [15:0] pcnt_q, pcnt_d, rdata_q, rdata_d;
  logic [2:0]  off;
  logic        sel, wr, rd, tick, expire;
  always_comb begin
    off = bus.addr[2:0];
    sel = bus.addr[7:3] == BASE_ADDR[7:3];
    wr = bus.write_enable && sel;
    rd = bus.read_enable && sel;
    tick = en_q && pcnt_q == prescale_q;
    expire = tick && count_q == 16'd0;
    en_d = wr && off == 3'd0 ? bus.write_data[0] : expire && !periodic_q ? 1'b0 : en_q;
    periodic_d = wr && off == 3'd0 ? bus.write_data[1] : periodic_q;
    irq_en_d = wr && off == 3'd0 ? bus.write_data[2] : irq_en_q;
    load_d = wr && off == 3'd1 ? bus.write_data : load_q;
    prescale_d = wr && off == 3'd3 ? bus.write_data : prescale_q;
    // a software COUNT write overrides any decrement or reload on the same edge
    count_d = wr && off == 3'd2 ? bus.write_data :
              !tick ? count_q :
              count_q != 16'd0 ? count_q - 16'd1 :
              periodic_q ? load_q : count_q;
    expired_d = expire | (expired_q & ~(wr && off == 3'd4 && bus.write_data[0]));
    // pcnt sits at 0 whenever disabled, so re-enabling always starts a full period
    pcnt_d = en_q && !tick ? pcnt_q + 16'd1 : 16'd0;
    rdata_d = !rd ? 16'd0 :
              off == 3'd0 ? {13'd0, irq_en_q, periodic_q, en_q} :
              off == 3'd1 ? load_q :
              off == 3'd2 ? count_q :
              off == 3'd3 ? prescale_q :
              off == 3'd4 ? {15'd0, expired_q} : 16'd0;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      en_q       <= 1'b0;
      periodic_q <= 1'b0;
      irq_en_q   <= 1'b0;
      expired_q  <= 1'b0;
      load_q     <= 16'd0;
      count_q    <= 16'd0;
      prescale_q <= RESET_PRESCALE;
      pcnt_q     <= 16'd0;
      rdata_q    <= 16'd0;
    end else begin
      en_q       <= en_d;
      periodic_q <= periodic_d;
      irq_en_q   <= irq_en_d;
      expired_q  <= expired_d;
      load_q     <= load_d;
      count_q    <= count_d;
      prescale_q <= prescale_d;
      pcnt_q     <= pcnt_d;
      rdata_q    <= rdata_d;
    end
  end
  assign bus.read_data = rdata_q;
  assign bus.irq = expired_q & irq_en_q;
endmodule

// File: tb/tb_peri_timer.sv
// tb_peri_timer: directed and randomized checks of peri_timer against an arithmetic timing model
module tb_peri_timer;
  localparam logic [7:0]  BA = 8'h10;
  localparam logic [15:0] RP = 16'h0005;
  logic clock = 1'b0, reset = 1'b1;
  int cyc = 0, tests = 0, fails = 0;
  peri_timer_if bus ();
  peri_timer #(.BASE_ADDR(BA), .RESET_PRESCALE(RP)) dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask
  task automatic bus_write(input logic [7:0] a, input logic [15:0] d);
    bus.addr = a; bus.write_data = d; bus.write_enable = 1'b1;
    @(negedge clock);
    bus.write_enable = 1'b0;
  endtask
  task automatic bus_read(input logic [7:0] a, output logic [15:0] d);
    bus.addr = a; bus.read_enable = 1'b1;
    @(negedge clock);
    bus.read_enable = 1'b0;
    d = bus.read_data;
  endtask
  task automatic wait_irq(input int lim, output int t);
    t = -1;
    for (int i = 0; i < lim; i++) begin
      if (bus.irq) begin t = cyc; break; end
      @(negedge clock);
    end
  endtask
  task automatic test_reset;
    logic [15:0] v, e;
    bus_write(BA + 3, 16'd2); bus_write(BA + 2, 16'd5); bus_write(BA + 0, 16'd7);
    idle(4);
    reset = 1'b1; @(negedge clock); reset = 1'b0;
    tests++; if (bus.irq !== 1'b0) begin fails++; $display("FAIL reset_irq: got %b want 0", bus.irq); end
    for (int o = 0; o < 8; o++) begin
      bus_read(BA + 8'(o), v);
      e = o == 3 ? RP : 16'd0;
      tests++; if (v !== e) begin fails++; $display("FAIL reset_reg%0d: got %h want %h", o, v, e); end
    end
  endtask
  task automatic test_decode;
    logic [15:0] v, e;
    bus_write(8'h12, 16'h0055);
    bus_read(8'h12, v);
    tests++; if (v !== 16'h0055) begin fails++; $display("FAIL dec_read: got %h want 0055", v); end
    idle(1);
    tests++; if (bus.read_data !== 16'd0) begin fails++; $display("FAIL dec_idle: got %h want 0000", bus.read_data); end
    bus_read(8'h22, v);
    tests++; if (v !== 16'd0) begin fails++; $display("FAIL dec_foreign_read: got %h want 0000", v); end
    bus_write(8'h22, 16'h0099); bus_write(8'h21, 16'h0009); bus_write(8'h23, 16'h0001);
    bus_write(BA + 5, 16'hFFFF); bus_write(BA + 6, 16'hFFFF); bus_write(BA + 7, 16'hFFFF);
    for (int o = 0; o < 8; o++) begin
      bus_read(BA + 8'(o), v);
      e = o == 2 ? 16'h0055 : o == 3 ? RP : 16'd0;
      tests++; if (v !== e) begin fails++; $display("FAIL dec_reg%0d: got %h want %h", o, v, e); end
    end
  endtask
  task automatic test_rdw;
    logic [15:0] v;
    bus_write(BA + 1, 16'h0007);
    bus.addr = BA + 1; bus.write_data = 16'h1234; bus.write_enable = 1'b1; bus.read_enable = 1'b1;
    @(negedge clock);
    bus.write_enable = 1'b0; bus.read_enable = 1'b0;
    tests++; if (bus.read_data !== 16'h0007) begin fails++; $display("FAIL rdw_old: got %h want 0007", bus.read_data); end
    bus_read(BA + 1, v);
    tests++; if (v !== 16'h1234) begin fails++; $display("FAIL rdw_new: got %h want 1234", v); end
  endtask
  task automatic test_periodic;
    logic [15:0] v;
    int e0, t;
    bus_write(BA + 0, 0); bus_write(BA + 4, 1);
    bus_write(BA + 3, 3); bus_write(BA + 1, 4); bus_write(BA + 2, 4); bus_write(BA + 0, 7);
    e0 = cyc;
    for (int k = 1; k <= 3; k++) begin
      wait_irq(40, t);
      tests++; if (t - e0 !== 20 * k) begin fails++; $display("FAIL per_interval%0d: got %0d want %0d", k, t - e0, 20 * k); end
      bus_read(BA + 2, v);
      tests++; if (v !== 16'd4) begin fails++; $display("FAIL per_reload%0d: got %h want 0004", k, v); end
      bus_write(BA + 4, 0);
      tests++; if (bus.irq !== 1'b1) begin fails++; $display("FAIL per_sticky%0d: got %b want 1", k, bus.irq); end
      bus_write(BA + 4, 1);
      tests++; if (bus.irq !== 1'b0) begin fails++; $display("FAIL per_clear%0d: got %b want 0", k, bus.irq); end
    end
    bus_write(BA + 0, 0);
  endtask
  task automatic test_oneshot;
    logic [15:0] v;
    int e0, t;
    bus_write(BA + 4, 1); bus_write(BA + 3, 0); bus_write(BA + 2, 2); bus_write(BA + 0, 5);
    e0 = cyc;
    wait_irq(20, t);
    tests++; if (t - e0 !== 3) begin fails++; $display("FAIL os_time: got %0d want 3", t - e0); end
    bus_read(BA + 0, v);
    tests++; if (v !== 16'h0004) begin fails++; $display("FAIL os_ctrl: got %h want 0004", v); end
    bus_read(BA + 2, v);
    tests++; if (v !== 16'd0) begin fails++; $display("FAIL os_count: got %h want 0000", v); end
    tests++; if (bus.irq !== 1'b1) begin fails++; $display("FAIL os_irq: got %b want 1", bus.irq); end
    bus_write(BA + 4, 1);
    idle(10);
    tests++; if (bus.irq !== 1'b0) begin fails++; $display("FAIL os_no_more: got %b want 0", bus.irq); end
    bus_read(BA + 4, v);
    tests++; if (v !== 16'd0) begin fails++; $display("FAIL os_status: got %h want 0000", v); end
  endtask
  task automatic test_collisions;
    logic [15:0] v;
    bus_write(BA + 0, 0); bus_write(BA + 4, 1); bus_write(BA + 3, 0); bus_write(BA + 2, 3); bus_write(BA + 0, 5);
    idle(3);
    bus_write(BA + 4, 1);
    bus_read(BA + 4, v);
    tests++; if (v !== 16'd1) begin fails++; $display("FAIL col_status: got %h want 0001", v); end
    bus_write(BA + 0, 0); bus_write(BA + 4, 1); bus_write(BA + 3, 1); bus_write(BA + 1, 9); bus_write(BA + 2, 9); bus_write(BA + 0, 3);
    idle(1);
    bus_write(BA + 2, 16'h00AA);
    bus_read(BA + 2, v);
    tests++; if (v !== 16'h00AA) begin fails++; $display("FAIL col_count: got %h want 00aa", v); end
    bus_write(BA + 0, 0); bus_write(BA + 4, 1); bus_write(BA + 3, 0); bus_write(BA + 2, 1); bus_write(BA + 0, 1);
    idle(1);
    bus_write(BA + 0, 1);
    bus_read(BA + 0, v);
    tests++; if (v !== 16'h0001) begin fails++; $display("FAIL col_ctrl: got %h want 0001", v); end
    bus_read(BA + 4, v);
    tests++; if (v !== 16'd1) begin fails++; $display("FAIL col_ctrl_status: got %h want 0001", v); end
    bus_write(BA + 0, 0); bus_write(BA + 4, 1); bus_write(BA + 3, 0); bus_write(BA + 1, 2); bus_write(BA + 2, 0); bus_write(BA + 0, 3);
    bus_write(BA + 1, 7);
    bus_read(BA + 2, v);
    tests++; if (v !== 16'd2) begin fails++; $display("FAIL col_load: got %h want 0002", v); end
    bus_write(BA + 0, 0);
  endtask
  // model: tick n lands n*(P+1) clocks after enable; expiry on tick C+1, then every L+1 ticks
  task automatic test_random;
    logic [15:0] v, e;
    int p, l, c, per, e0, n;
    for (int it = 0; it < 10; it++) begin
      p = $urandom_range(0, 3); l = $urandom_range(0, 5); c = $urandom_range(0, 5); per = $urandom_range(0, 1);
      bus_write(BA + 0, 0); bus_write(BA + 4, 1);
      bus_write(BA + 3, 16'(p)); bus_write(BA + 1, 16'(l)); bus_write(BA + 2, 16'(c));
      bus_write(BA + 0, {13'd0, 1'b1, per[0], 1'b1});
      e0 = cyc;
      for (int r = 0; r < 5; r++) begin
        idle($urandom_range(0, 12));
        bus_read(BA + 2, v);
        n = (cyc - 1 - e0) / (p + 1);
        e = n <= c ? 16'(c - n) : per != 0 ? 16'(l - ((n - c - 1) % (l + 1))) : 16'd0;
        tests++; if (v !== e) begin fails++; $display("FAIL rnd_count: got %h want %h (p=%0d l=%0d c=%0d per=%0d)", v, e, p, l, c, per); end
        bus_read(BA + 0, v);
        n = (cyc - 1 - e0) / (p + 1);
        e = {13'd0, 1'b1, per[0], per != 0 || n <= c};
        tests++; if (v !== e) begin fails++; $display("FAIL rnd_ctrl: got %h want %h", v, e); end
        n = (cyc - e0) / (p + 1);
        tests++; if (bus.irq !== (n > c)) begin fails++; $display("FAIL rnd_irq: got %b want %b", bus.irq, n > c); end
      end
    end
    bus_write(BA + 0, 0);
  endtask
  initial begin
    bus.addr = 8'd0; bus.write_data = 16'd0; bus.write_enable = 1'b0; bus.read_enable = 1'b0;
    idle(2);
    reset = 1'b0;
    test_reset;
    test_decode;
    test_rdw;
    test_periodic;
    test_oneshot;
    test_collisions;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
